alu_seq: RTL and testbench

Multi-precision sequencer for the shared 4-bit slice ALU. It accepts one wide operation (WORDS nibbles per operand) over a valid/ready request port and issues it to the external 4-bit ALU one nibble per cycle, LSB nibble first. It chains the carry through a register between nibbles and returns the assembled result with carry, overflow and zero flags on a valid/ready response port. It sits between any wide-operand client and a single ALU4 instance, so that one 4-bit slice serves arbitrary word widths.

---
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-precision sequencer: issues a WORDS-nibble operation to a 4-bit slice ALU, LSB nibble first.
// Optional feature: define ALU_SEQ_ABORT_EN to add the abort input.
module alu_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*WORDS-1:0]   req_a,
  input  logic [4*WORDS-1:0]   req_b,
  input  logic [3:0]           req_s,
  input  logic                 req_m,
  input  logic                 req_cin,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cin,
  input  logic [3:0]           alu_do,
  input  logic                 alu_co,
  input  logic                 alu_v,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*WORDS-1:0]   rsp_do,
  output logic                 rsp_co,
  output logic                 rsp_v,
`ifdef ALU_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 rsp_z
);

  localparam int unsigned W  = 4 * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned SW = IW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  op_a, op_b, result, res_nx;
  logic [3:0]    op_s;
  logic          op_m;
  logic          carry;
  logic [IW-1:0] idx;
  logic [SW-1:0] sh;
  logic          last, abort_hit, accept, step;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign sh     = {idx, 2'b00};
  assign last   = (idx == IW'(WORDS - 1));
  assign accept = (state == IDLE) && req_valid;
  assign step   = (state == RUN) && !abort_hit;

  // result with the current ALU nibble merged in; zero flag looks at this
  assign res_nx = (result & ~(W'(4'hF) << sh)) | (W'(alu_do) << sh);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_hit) state_nx = IDLE;
  end

  // operand latch, nibble stepping and flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_s   <= '0;
      op_m   <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      rsp_co <= 1'b0;
      rsp_v  <= 1'b0;
      rsp_z  <= 1'b0;
    end else if (accept) begin
      op_a   <= req_a;
      op_b   <= req_b;
      op_s   <= req_s;
      op_m   <= req_m;
      carry  <= req_cin;
      idx    <= '0;
      result <= '0;
    end else if (step) begin
      result <= res_nx;
      carry  <= alu_co;
      idx    <= last ? '0 : idx + IW'(1);
      if (last) begin
        rsp_co <= alu_co;
        rsp_v  <= alu_v;
        rsp_z  <= (res_nx == '0);
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_do    = result;
  assign alu_s     = op_s;
  assign alu_m     = op_m;
  assign alu_a     = (state == RUN) ? 4'(op_a >> sh) : 4'h0;
  assign alu_b     = (state == RUN) ? 4'(op_b >> sh) : 4'h0;
  assign alu_cin   = (state == RUN) ? carry : 1'b0;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WORDS=4) with an adder stub on the ALU return path and a wide-arithmetic model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_m, req_cin;
  logic [15:0] req_a, req_b, rsp_do;
  logic [3:0]  req_s, alu_a, alu_b, alu_s, alu_do;
  logic        alu_m, alu_cin, alu_co, alu_v;
  logic        rsp_valid, rsp_ready, rsp_co, rsp_v, rsp_z;
  logic [4:0]  stub_sum;
`ifdef ALU_SEQ_ABORT_EN
  logic        abort;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int prev_acc = 0;
  int next_iv = -1;
  logic [3:0]  cin_seq;
  logic [15:0] last_do;
  logic        last_co, last_v, last_z;

  alu_seq #(.WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_do(alu_do), .alu_co(alu_co), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_do(rsp_do),
    .rsp_co(rsp_co), .rsp_v(rsp_v),
`ifdef ALU_SEQ_ABORT_EN
    .abort(abort),
`endif
    .rsp_z(rsp_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: plain 4-bit add with signed overflow
  always_comb begin
    stub_sum = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
    {alu_co, alu_do} = stub_sum;
    alu_v = (alu_a[3] == alu_b[3]) && (stub_sum[3] != alu_a[3]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // present a request at a negedge; acceptance happens at the following posedge
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [3:0] s, input logic m);
    check("req_ready_idle", req_ready, 1'b1);
    if (next_iv >= 0) check("accept_interval", cyc - prev_acc, next_iv);
    prev_acc = cyc;
    req_a = a; req_b = b; req_cin = cin; req_s = s; req_m = m; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    req_a = 16'(~a);
  endtask

  // walk the RUN cycles and check the response against wide arithmetic
  task automatic run_check(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [3:0] s, input logic m);
    logic [16:0] full;
    logic [16:0] low;
    logic        exp_v;
    for (int k = 0; k < 4; k++) begin
      low = 17'(a & 16'((32'd1 << (4*k)) - 1)) + 17'(b & 16'((32'd1 << (4*k)) - 1)) + 17'(cin);
      check("alu_a", alu_a, 4'(a >> (4*k)));
      check("alu_b", alu_b, 4'(b >> (4*k)));
      check("alu_cin", alu_cin, low[4*k]);
      check("alu_s", alu_s, s);
      check("alu_m", alu_m, m);
      check("rsp_valid_run", rsp_valid, 1'b0);
      check("req_ready_run", req_ready, 1'b0);
      cin_seq[k] = alu_cin;
      @(posedge clk); @(negedge clk);
    end
    full  = 17'(a) + 17'(b) + 17'(cin);
    exp_v = (a[15] == b[15]) && (full[15] != a[15]);
    check("rsp_valid_done", rsp_valid, 1'b1);
    check("rsp_do", rsp_do, full[15:0]);
    check("rsp_co", rsp_co, full[16]);
    check("rsp_v", rsp_v, exp_v);
    check("rsp_z", rsp_z, full[15:0] == 16'h0);
    check("alu_a_done", alu_a, 4'h0);
    check("alu_cin_done", alu_cin, 1'b0);
    last_do = rsp_do; last_co = rsp_co; last_v = rsp_v; last_z = rsp_z;
  endtask

  // hold off the response for bp cycles, then accept it
  task automatic finish_rsp(input int bp);
    logic [15:0] exp_do;
    exp_do = rsp_do;
    rsp_ready = (bp == 0);
    for (int i = 0; i < bp; i++) begin
      req_valid = (i == 3);
      req_a = 16'h1234;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_do", rsp_do, exp_do);
      check("bp_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
    next_iv = 6 + bp;
  endtask

  task automatic full_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [3:0] s, input logic m, input int bp);
    issue(a, b, cin, s, m);
    run_check(a, b, cin, s, m);
    finish_rsp(bp);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0;
    req_cin = 1'b0; rsp_ready = 1'b1;
`ifdef ALU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_do", rsp_do, 16'h0000);
    check("rst_flags", {rsp_co, rsp_v, rsp_z}, 3'b000);
    check("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, 14'h0);

    // carry chain
    full_op(16'h0FFF, 16'h0001, 1'b0, 4'h9, 1'b0, 0);
    check("chain_cin_seq", cin_seq, 4'b1110);
    check("chain_do", last_do, 16'h1000);
    check("chain_flags", {last_co, last_v, last_z}, 3'b000);

    // flags, back to back
    full_op(16'h7FFF, 16'h0001, 1'b0, 4'h3, 1'b1, 0);
    check("ovf_do", last_do, 16'h8000);
    check("ovf_flags", {last_co, last_v}, 2'b01);
    full_op(16'hFFFF, 16'h0001, 1'b0, 4'h6, 1'b0, 10);
    check("wrap_do", last_do, 16'h0000);
    check("wrap_flags", {last_co, last_z, last_v}, 3'b110);

    // next op after 10 cycles of backpressure
    full_op(16'h1357, 16'h2468, 1'b1, 4'hA, 1'b1, 0);

    // reset mid-RUN: rst high at the 2nd RUN edge
    issue(16'hABCD, 16'h1111, 1'b0, 4'h1, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_alu_a", alu_a, 4'h0);
    for (int i = 0; i < 6; i++) begin
      check("mid_rst_no_rsp", rsp_valid, 1'b0);
      @(posedge clk); @(negedge clk);
    end
    next_iv = -1;
    full_op(16'h8001, 16'h8001, 1'b1, 4'h2, 1'b0, 0);

`ifdef ALU_SEQ_ABORT_EN
    // abort at the 3rd RUN edge
    issue(16'h4444, 16'h5555, 1'b0, 4'h0, 1'b0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    check("abort_run_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("abort_run_no_rsp", rsp_valid, 1'b0);
      @(posedge clk); @(negedge clk);
    end
    // abort in DONE
    next_iv = -1;
    issue(16'h0F0F, 16'h00F1, 1'b0, 4'h0, 1'b0);
    rsp_ready = 1'b0;
    run_check(16'h0F0F, 16'h00F1, 1'b0, 4'h0, 1'b0);
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    rsp_ready = 1'b1;
    check("abort_done_valid", rsp_valid, 1'b0);
    check("abort_done_ready", req_ready, 1'b1);
    next_iv = -1;
`endif

    // randomized operations with random backpressure
    for (int n = 0; n < 24; n++) begin
      full_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
